// File: rtl/uart2_tx_pkg.sv
// rtl/uart2_tx_pkg.sv - shared uart2 frame constants and transmitter state encoding
package uart2_tx_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int TICK_W     = $clog2(OVERSAMPLE);
    localparam int BIT_W      = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart2_tx_if.sv
// rtl/uart2_tx_if.sv - host-side request/status bundle of the uart2 transmitter
interface uart2_tx_if;
    import uart2_tx_pkg::*;

    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 tx_overrun;

    modport master (
        output tx_start, tx_data,
        input  tx_ready, tx_busy, tx_done, tx_overrun
    );

    modport slave (
        input  tx_start, tx_data,
        output tx_ready, tx_busy, tx_done, tx_overrun
    );
endinterface

// File: rtl/uart2_tx.sv
// rtl/uart2_tx.sv - 8N1 UART transmitter with a one-entry holding register
module uart2_tx
    import uart2_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       b_tick,
    output logic       tx,
    uart2_tx_if.slave  host
);

    tx_state_t            state, state_d;
    logic [TICK_W-1:0]    tick_cnt, tick_d;
    logic [BIT_W-1:0]     bit_cnt, bit_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic [DATA_BITS-1:0] hold, hold_d;
    logic                 hold_valid, hold_valid_d;
    logic                 tx_d;
    logic                 last_tick;
    logic                 stop_end;

    assign last_tick = b_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
    assign stop_end  = (state == STOP) && last_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (host.tx_start) state_d = START;
            START: if (last_tick) state_d = DATA;
            DATA:  if (last_tick && bit_cnt == BIT_W'(DATA_BITS - 1)) state_d = STOP;
            STOP:  if (last_tick) state_d = (hold_valid || host.tx_start) ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        host.tx_busy    = (state != IDLE);
        host.tx_ready   = ~hold_valid;
        host.tx_done    = stop_end;
        // At stop completion a full holding slot drains, so a new request still fits.
        host.tx_overrun = host.tx_start && hold_valid && !stop_end;
    end

    always_comb begin
        shift_d      = shift;
        hold_d       = hold;
        hold_valid_d = hold_valid;
        tick_d       = tick_cnt;
        bit_d        = bit_cnt;
        if (state == IDLE) begin
            if (host.tx_start) begin
                shift_d = host.tx_data;
                tick_d  = '0;
            end
        end else begin
            if (b_tick) tick_d = last_tick ? '0 : tick_cnt + 1'b1;
            if (state == START && last_tick) bit_d = '0;
            if (state == DATA && last_tick && bit_cnt != BIT_W'(DATA_BITS - 1)) begin
                shift_d = shift >> 1;
                bit_d   = bit_cnt + 1'b1;
            end
            if (stop_end) begin
                if (hold_valid) begin
                    shift_d = hold;
                    if (host.tx_start) hold_d = host.tx_data;
                    else               hold_valid_d = 1'b0;
                end else if (host.tx_start) begin
                    shift_d = host.tx_data;
                end
            end else if (host.tx_start && !hold_valid) begin
                hold_d       = host.tx_data;
                hold_valid_d = 1'b1;
            end
        end
    end

    // Line level for the coming state, so tx itself is a plain flop.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            tx         <= 1'b1;
        end else begin
            tick_cnt   <= tick_d;
            bit_cnt    <= bit_d;
            shift      <= shift_d;
            hold       <= hold_d;
            hold_valid <= hold_valid_d;
            tx         <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart2_tx.sv
// tb/tb_uart2_tx.sv - scoreboard bench: timing model of frames plus serial-line decoder
module tb_uart2_tx;
    import uart2_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic b_tick = 1'b0;
    logic tx;

    uart2_tx_if ifc ();

    uart2_tx dut (
        .clk    (clk),
        .rst    (rst),
        .b_tick (b_tick),
        .tx     (tx),
        .host   (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         a;
        int         s;
        int         e;
        logic [7:0] d;
    } frame_t;

    frame_t     fr[$];
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         ovr_exp = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        b_tick       = (cyc % 4 == 0);
        ifc.tx_start = 1'b0;
        ovr_exp      = 1'b0;
    endtask

    function automatic int n_after(int c);
        int n = 0;
        foreach (fr[i]) if (fr[i].e > c) n++;
        return n;
    endfunction

    task automatic send(logic [7:0] d);
        frame_t f;
        int     t1;
        ifc.tx_start = 1'b1;
        ifc.tx_data  = d;
        if (n_after(cyc) < 2) begin
            f.a = cyc;
            f.d = d;
            if (n_after(cyc) == 0) begin
                t1  = ((cyc + 4) / 4) * 4;
                f.s = cyc + 1;
                f.e = t1 + 4 * (10 * OVERSAMPLE - 1);
            end else begin
                f.s = fr[$].e + 1;
                f.e = fr[$].e + 4 * 10 * OVERSAMPLE;
            end
            fr.push_back(f);
            exp_q.push_back(d);
        end else begin
            ovr_exp = 1'b1;
        end
    endtask

    task automatic wait_idle(string nm);
        int n = 0;
        while (n_after(cyc - 1) != 0 && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) chk({nm, "_timeout"}, 1, 0);
        repeat (8) step();
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Per-cycle expectations derived from the frame schedule.
    always @(negedge clk) begin
        if (!rst) begin
            logic e_busy, e_done, e_tx;
            int   nh;
            e_busy = 0; e_done = 0; e_tx = 1; nh = 0;
            foreach (fr[i]) begin
                if (fr[i].a < cyc && fr[i].e >= cyc) nh++;
                if (fr[i].e == cyc) e_done = 1;
                if (fr[i].s <= cyc && cyc <= fr[i].e) begin
                    int b;
                    e_busy = 1;
                    b = ((cyc - 1) / 4 - (fr[i].s - 1) / 4) / OVERSAMPLE;
                    e_tx = (b == 0) ? 1'b0 : (b >= 9) ? 1'b1 : fr[i].d[b - 1];
                end
            end
            chk("tx_line", tx, e_tx);
            chk("tx_busy", ifc.tx_busy, e_busy);
            chk("tx_ready", ifc.tx_ready, nh != 2);
            chk("tx_done", ifc.tx_done, e_done);
            chk("tx_overrun", ifc.tx_overrun, ovr_exp);
        end
    end

    // Serial decoder: mid-bit sampling after each falling edge, pops the scoreboard.
    bit         mon_act = 0;
    int         mcnt = 0;
    logic [7:0] mbyte;
    always @(negedge clk) begin
        if (rst) begin
            mon_act = 0;
        end else if (!mon_act) begin
            if (tx == 1'b0) begin
                mon_act = 1;
                mcnt = 0;
            end
        end else begin
            mcnt++;
            if (mcnt % 64 == 30) begin
                int j;
                j = mcnt / 64;
                if (j == 0) begin
                    chk("start_bit", tx, 0);
                end else if (j <= 8) begin
                    mbyte[j - 1] = tx;
                end else begin
                    chk("stop_bit", tx, 1);
                    if (exp_q.size() == 0) chk("unexpected_frame", mbyte, 32'hFFFF_FFFF);
                    else chk("rx_byte", mbyte, exp_q.pop_front());
                    mon_act = 0;
                end
            end
        end
    end

    initial begin
        ifc.tx_start = 1'b0;
        ifc.tx_data  = '0;
        repeat (3) step();
        chk("rst_tx", tx, 1);
        chk("rst_busy", ifc.tx_busy, 0);
        chk("rst_ready", ifc.tx_ready, 1);
        chk("rst_done", ifc.tx_done, 0);
        chk("rst_overrun", ifc.tx_overrun, 0);
        rst = 1'b0;

        repeat (1000) step();

        step(); send(8'hA5);
        wait_idle("single_a5");

        step(); send(8'h00);
        repeat (100) step();
        send(8'hFF);
        wait_idle("back_to_back");

        step(); send(8'h12);
        repeat (50) step();  send(8'h34);
        repeat (50) step();  send(8'h56);
        wait_idle("overrun");

        step(); send(8'h9C);
        repeat (40) step(); send(8'h63);
        begin
            int e0, n;
            e0 = fr[fr.size() - 2].e;
            n = 0;
            while (cyc < e0 && n < 2000) begin step(); n++; end
            chk("stop_edge_reached", cyc, e0);
            send(8'hC3);
        end
        wait_idle("start_at_stop");

        step(); send(8'h3C);
        repeat (200) step();
        #2 rst = 1'b1;
        #1;
        chk("midframe_rst_tx", tx, 1);
        chk("midframe_rst_busy", ifc.tx_busy, 0);
        chk("midframe_rst_ready", ifc.tx_ready, 1);
        fr.delete();
        exp_q.delete();
        step(); step();
        rst = 1'b0;
        repeat (5) step();
        send(8'h81);
        wait_idle("after_reset");

        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = $urandom_range(0, 700);
            repeat (gap) step();
            step();
            send(8'($urandom));
        end
        wait_idle("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
